spi_mem_ctrl: RTL and testbench

Memory-side responder for the control unit's `mem_ctrl_op` / `mem_op_done` handshake. It accepts single-byte read and write requests at a supplied address and executes each one as an SPI mode-0 transaction to an external serial SRAM (23LC512-style command set). For reads it returns the data byte to the bus mux. It also raises the one-cycle completion pulse that the control FSM waits on.

---
 rtl/spi_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl
//   Memory-side responder for the control unit's mem_ctrl_op / mem_op_done
//   handshake. Each MEM_READ / MEM_WRITE is executed as one SPI mode-0 frame
//   to a 23LC512-style serial SRAM:
//     [8-bit cmd (0x03 rd / 0x02 wr)][16-bit addr][8-bit data], MSB first.
//   Every bit is two clock cycles (sclk low, then sclk high). MISO is sampled
//   on the clock edge that ends the sclk-high cycle. DONE is a single cycle
//   with cs_n high and mem_op_done high; the following cycle is IDLE.
//
//   Handshake: a request is accepted whenever it is present in an IDLE
//   cycle. While a frame is in progress mem_ctrl_op is ignored. Every
//   accepted request gets exactly one mem_op_done pulse. A request still
//   held in the IDLE cycle after DONE starts a new transaction.
//
//   Optional feature, macro SPI_MEM_CACHE_EN: one-entry write-through read
//   cache. A read hit skips the SPI frame and reaches DONE one cycle after
//   the request is sampled.
//
// Ports
//   clock, reset      : clock, asynchronous active-low reset
//   mem_ctrl_op       : request (MEM_READ / MEM_WRITE start, others NOP)
//   addr, data_in     : address / write data, sampled with the request
//   data_out          : last byte read (bus mux MUX_MEM input)
//   mem_op_done       : one-cycle completion pulse
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso : serial SRAM interface
//   fsm_state         : current FSM state, for observation only

package spi_mem_pkg;
  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } spi_state_e;
endpackage

module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,   // SPI framing assumes 8
  parameter int ADDR_WIDTH     = 16   // must be <= 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  mem_ctrl_op_e              mem_ctrl_op,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_BUS_WIDTH-1:0] data_in,
  output logic [DATA_BUS_WIDTH-1:0] data_out,
  output logic                      mem_op_done,
  output logic                      spi_cs_n,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  input  logic                      spi_miso,
  output spi_state_e                fsm_state
);

  spi_state_e  state_q, state_d;
  logic [4:0]  bit_cnt_q;   // bit index within the 32-bit frame
  logic        phase_q;     // 0: sclk-low half of a bit, 1: sclk-high half
  logic [31:0] sreg_q;      // outgoing frame, MSB on the wire
  logic [7:0]  rx_q;        // incoming bits; the last 8 are the data field
  logic        is_read_q;

  logic [15:0] addr_ext;
  logic        req, rd, hit, frame_end;

`ifdef SPI_MEM_CACHE_EN
  logic        cache_valid_q;
  logic [15:0] cache_addr_q;
  logic [7:0]  cache_data_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
`endif

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_WIDTH-1:0] = addr;
  end

  assign rd  = (mem_ctrl_op == MEM_READ);
  assign req = rd || (mem_ctrl_op == MEM_WRITE);

`ifdef SPI_MEM_CACHE_EN
  assign hit = rd && cache_valid_q && (cache_addr_q == addr_ext);
`else
  assign hit = 1'b0;
`endif

  // Last edge of the frame: sclk-high half of bit 31.
  assign frame_end = (state_q == ST_DATA) && phase_q && (bit_cnt_q == 5'd31);

  // Next state and outputs. Serial outputs decode directly from registers.
  always_comb begin
    state_d     = state_q;
    spi_cs_n    = 1'b1;
    spi_sclk    = 1'b0;
    spi_mosi    = 1'b0;
    mem_op_done = 1'b0;
    case (state_q)
      ST_IDLE: if (req) state_d = hit ? ST_DONE : ST_CMD;
      ST_CMD:  if (phase_q && bit_cnt_q == 5'd7)  state_d = ST_ADDR;
      ST_ADDR: if (phase_q && bit_cnt_q == 5'd23) state_d = ST_DATA;
      ST_DATA: if (frame_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) begin
      spi_cs_n = 1'b0;
      spi_sclk = phase_q;
      spi_mosi = sreg_q[31];
    end
    if (state_q == ST_DONE) mem_op_done = 1'b1;
  end

  assign fsm_state = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      sreg_q    <= '0;
      rx_q      <= '0;
      is_read_q <= 1'b0;
      data_out  <= '0;
`ifdef SPI_MEM_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            is_read_q <= rd;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            sreg_q    <= {(rd ? 8'h03 : 8'h02), addr_ext, (rd ? 8'h00 : data_in)};
`ifdef SPI_MEM_CACHE_EN
            addr_q  <= addr_ext;
            wdata_q <= data_in;
            if (hit) data_out <= cache_data_q;
`endif
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          phase_q <= !phase_q;
          if (phase_q) begin
            // bit_cnt wraps from 31 back to 0 at the end of the frame
            bit_cnt_q <= bit_cnt_q + 5'd1;
            sreg_q    <= {sreg_q[30:0], 1'b0};
            rx_q      <= {rx_q[6:0], spi_miso};
          end
          if (frame_end) begin
            if (is_read_q) data_out <= {rx_q[6:0], spi_miso};
`ifdef SPI_MEM_CACHE_EN
            cache_valid_q <= 1'b1;
            cache_addr_q  <= addr_q;
            cache_data_q  <= is_read_q ? {rx_q[6:0], spi_miso} : wdata_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl. A cycle-count model predicts the SPI waveform and
// handshake outputs from the request alone; an SPI slave model serves MISO
// and records MOSI so each frame can also be pinned to literal values.
module tb_spi_mem_ctrl;
  import spi_mem_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  mem_ctrl_op_e op = MEM_NOP;
  logic [15:0]  req_addr = '0;
  logic [7:0]   req_data = '0;
  logic [7:0]   data_out;
  logic         mem_op_done, spi_cs_n, spi_sclk, spi_mosi, spi_miso;
  spi_state_e   fsm_state;

  int tests_run = 0;
  int fails = 0;
  int done_cnt = 0;

`ifdef SPI_MEM_CACHE_EN
  localparam int HIT_LAT   = 1;
  localparam bit HIT_FRAME = 1'b0;
`else
  localparam int HIT_LAT   = 65;
  localparam bit HIT_FRAME = 1'b1;
`endif

  spi_mem_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .mem_ctrl_op(op), .addr(req_addr),
    .data_in(req_data), .data_out(data_out), .mem_op_done(mem_op_done),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- SPI slave: byte served on the data field ----------------
  logic [7:0]  miso_byte = 8'h00;
  int          slv_cnt = 0;      // sclk rising edges since cs_n fell
  logic [31:0] slave_rx = '0;    // MOSI bits captured on sclk rising
  int          cs_falls = 0;

  always @(posedge spi_sclk or negedge spi_cs_n) begin
    if (!spi_sclk) slv_cnt <= 0;
    else begin
      slv_cnt  <= slv_cnt + 1;
      slave_rx <= {slave_rx[30:0], spi_mosi};
    end
  end

  always @(negedge spi_cs_n) cs_falls <= cs_falls + 1;

  assign spi_miso = (!spi_cs_n && slv_cnt >= 25 && slv_cnt <= 32) ? miso_byte[32 - slv_cnt] : 1'b0;

  // ---------------- behavioural model ----------------
  // m_t counts cycles since the sampling edge (0 = idle); m_end is the done
  // cycle: 65 for an SPI frame, 1 for a cache hit.
  int          m_t = 0;
  int          m_end = 65;
  logic [31:0] m_frame = '0;
  logic        m_read = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_data_out = '0;
  logic        c_valid = 1'b0;
  logic [15:0] c_addr = '0;
  logic [7:0]  c_data = '0;
  logic        m_req, m_rd, m_hit;

  assign m_rd  = (op == MEM_READ);
  assign m_req = m_rd || (op == MEM_WRITE);
`ifdef SPI_MEM_CACHE_EN
  assign m_hit = m_rd && c_valid && (c_addr == req_addr);
`else
  assign m_hit = 1'b0;
`endif

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_t        <= 0;
      m_end      <= 65;
      m_data_out <= '0;
      c_valid    <= 1'b0;
    end else if (m_t == 0) begin
      if (m_req) begin
        m_read  <= m_rd;
        m_addr  <= req_addr;
        m_wdata <= req_data;
        m_frame <= {(m_rd ? 8'h03 : 8'h02), req_addr, (m_rd ? 8'h00 : req_data)};
        m_t     <= 1;
        if (m_hit) begin
          m_end      <= 1;
          m_data_out <= c_data;
        end else begin
          m_end <= 65;
        end
      end
    end else if (m_t == m_end) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == m_end) begin
        if (m_read) m_data_out <= miso_byte;
        c_valid <= 1'b1;
        c_addr  <= m_addr;
        c_data  <= m_read ? miso_byte : m_wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic in_frame, e_cs, e_sclk, e_mosi, e_done;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_frame = (m_end == 65) && (m_t >= 1) && (m_t <= 64);
        e_cs   = !in_frame;
        e_sclk = in_frame && (((m_t - 1) % 2) == 1);
        e_mosi = in_frame ? m_frame[31 - (m_t - 1) / 2] : 1'b0;
        e_done = (m_t != 0) && (m_t == m_end);
        tests_run++;
        if (spi_cs_n !== e_cs || spi_sclk !== e_sclk || spi_mosi !== e_mosi ||
            mem_op_done !== e_done || data_out !== m_data_out) begin
          fails++;
          $display("FAIL cycle t=%0d: got cs_n=%b sclk=%b mosi=%b done=%b dout=%h, want cs_n=%b sclk=%b mosi=%b done=%b dout=%h",
                   m_t, spi_cs_n, spi_sclk, spi_mosi, mem_op_done, data_out,
                   e_cs, e_sclk, e_mosi, e_done, m_data_out);
        end
      end
      if (mem_op_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Wait at most 200 cycles for done; returns cycles counted from the
  // sampling edge (1 = cycle 1). Drops the request at cycle 'hold'.
  task automatic wait_done(input int hold, input string name, output int cnt);
    bit seen;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(negedge clock);
      cnt++;
      if (cnt == hold) op = MEM_NOP;
      if (mem_op_done) seen = 1'b1;
    end
    if (!seen) begin
      fails++;
      tests_run++;
      $display("FAIL %s_timeout: got no done within %0d cycles, want done", name, cnt);
    end
  endtask

  task automatic do_txn(input mem_ctrl_op_e o, input logic [15:0] a, input logic [7:0] d,
                        input int hold, input int exp_lat, input logic [7:0] exp_data,
                        input bit frame_expected, input logic [31:0] exp_frame,
                        input string name);
    int cnt;
    int falls0;
    @(posedge clock); #1;
    op = o; req_addr = a; req_data = d;
    falls0 = cs_falls;
    @(posedge clock);
    wait_done(hold, name, cnt);
    op = MEM_NOP;
    check({name, "_latency"}, cnt, exp_lat);
    check({name, "_data_out"}, data_out, exp_data);
    if (frame_expected) check({name, "_frame"}, slave_rx, exp_frame);
    else                check({name, "_no_cs"}, cs_falls - falls0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int d0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_done", mem_op_done, 0);
    check("rst_data_out", data_out, 0);
    check("rst_state", fsm_state, ST_IDLE);
    @(negedge clock);
    reset = 1'b1;

    // basic read / write
    miso_byte = 8'hA5;
    do_txn(MEM_READ, 16'h0012, 8'h00, 1, 65, 8'hA5, 1'b1, 32'h0300_1200, "read");
    do_txn(MEM_WRITE, 16'hBEEF, 8'h3C, 1, 65, 8'hA5, 1'b1, 32'h02BE_EF3C, "write");

    // held request: two back-to-back frames, cs_n high for 2 cycles between
    @(posedge clock); #1;
    op = MEM_READ; req_addr = 16'h0020; miso_byte = 8'h11; d0 = done_cnt;
    @(posedge clock);
    wait_done(1000, "held1", cnt);
    check("held1_latency", cnt, 65);
    check("held1_data_out", data_out, 8'h11);
    check("held1_frame", slave_rx, 32'h0300_2000);
    @(posedge clock); #1;
    req_addr = 16'h0013; miso_byte = 8'h22;
    @(negedge clock);
    check("held_gap_idle_cs_n", spi_cs_n, 1);
    wait_done(1000, "held2", cnt);
    op = MEM_NOP;
    check("held2_latency", cnt, 65);
    check("held2_data_out", data_out, 8'h22);
    check("held2_frame", slave_rx, 32'h0300_1300);
    repeat (5) @(negedge clock);
    check("held_done_pulses", done_cnt - d0, 2);

    // request dropped at cycle 20 of a write
    do_txn(MEM_WRITE, 16'h1234, 8'h99, 20, 65, 8'h22, 1'b1, 32'h0212_3499, "drop");

    // reset at cycle 30 of a read
    @(posedge clock); #1;
    op = MEM_READ; req_addr = 16'h4444; miso_byte = 8'hE7; d0 = done_cnt;
    @(posedge clock);
    repeat (30) @(negedge clock);
    check("midrst_pre_sclk", spi_sclk, 1);
    op = MEM_NOP;
    #2 reset = 1'b0;
    #1;
    check("midrst_cs_n", spi_cs_n, 1);
    check("midrst_sclk", spi_sclk, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_done", mem_op_done, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("midrst_no_done", done_cnt - d0, 0);
    miso_byte = 8'h5A;
    do_txn(MEM_READ, 16'h0001, 8'h00, 1, 65, 8'h5A, 1'b1, 32'h0300_0100, "post_rst_read");

    // cache sequence (hit latency depends on build)
    miso_byte = 8'hC3;
    do_txn(MEM_READ, 16'h0040, 8'h00, 1, 65, 8'hC3, 1'b1, 32'h0300_4000, "c_read1");
    do_txn(MEM_READ, 16'h0040, 8'h00, 1, HIT_LAT, 8'hC3, HIT_FRAME, 32'h0300_4000, "c_read2");
    do_txn(MEM_WRITE, 16'h0040, 8'h77, 1, 65, 8'hC3, 1'b1, 32'h0200_4077, "c_write");
    miso_byte = 8'h77;
    do_txn(MEM_READ, 16'h0040, 8'h00, 1, HIT_LAT, 8'h77, HIT_FRAME, 32'h0300_4000, "c_read3");

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of sequence, want finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
